// File: rtl/seq_irrigacao.sv
// Irrigation sequencer: tank fill, post-fill cleaning, sprinkle and drip phases on a tick time base.
// All sensor and button inputs are synchronized; outputs are registered and one-hot decoded from state.
module seq_irrigacao #(
  parameter int T_LIMPA      = 5,
  parameter int T_ESP        = 15,
  parameter int T_ENCHER_MAX = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       botao,
  input  logic       us,
  input  logic       ua,
  input  logic       t,
  input  logic       nivel_baixo,
  input  logic       nivel_alto,
  output logic       bomba,
  output logic       limpeza,
  output logic       aspergir,
  output logic       gotejar,
  output logic       alarme,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENCHER   = 3'd1,
    LIMPAR   = 3'd2,
    ASPERGIR = 3'd3,
    GOTEJAR  = 3'd4,
    FALHA    = 3'd5
  } state_t;

  localparam logic [7:0] LIMPA_END  = 8'(T_LIMPA - 1);
  localparam logic [7:0] ESP_END    = 8'(T_ESP - 1);
  localparam logic [7:0] ENCHER_END = 8'(T_ENCHER_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic       botao_prev;
  logic [1:0] fill;
  logic       press;
  logic       botao_s, us_s, ua_s, t_s, nb_s, na_s;
  logic       caso_esp;

  assign {botao_s, us_s, ua_s, t_s, nb_s, na_s} = sync2;
  assign caso_esp = ua_s & ~t_s;
  // Edge detection is held off until the synchronizer holds real samples,
  // so a button held through reset release never looks like a press.
  assign press    = (fill == 2'd3) & botao_s & ~botao_prev;
  assign estado   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      botao_prev <= 1'b0;
      fill       <= 2'd0;
    end else begin
      sync1      <= {botao, us, ua, t, nivel_baixo, nivel_alto};
      sync2      <= sync1;
      botao_prev <= sync2[5];
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (press) begin
      state_nxt = OCIOSO;
    end else begin
      case (state)
        OCIOSO: if (tick) begin
          if (nb_s && na_s)              state_nxt = FALHA;
          else if (nb_s)                 state_nxt = ENCHER;
          else if (!us_s && ua_s && t_s) state_nxt = GOTEJAR;
          else if (!us_s)                state_nxt = ASPERGIR;
        end
        ENCHER: if (tick) begin
          if (nb_s && na_s)              state_nxt = FALHA;
          else if (na_s)                 state_nxt = LIMPAR;
          else if (cnt == ENCHER_END)    state_nxt = FALHA;
        end
        LIMPAR: if (tick) begin
          if (nb_s)                      state_nxt = ENCHER;
          else if (cnt == LIMPA_END)     state_nxt = OCIOSO;
        end
        ASPERGIR: if (tick) begin
          if (nb_s)                      state_nxt = ENCHER;
          else if (us_s)                 state_nxt = OCIOSO;
          else if (caso_esp && cnt == ESP_END) state_nxt = GOTEJAR;
        end
        GOTEJAR: if (tick) begin
          if (nb_s)                      state_nxt = ENCHER;
          else if (us_s)                 state_nxt = OCIOSO;
        end
        FALHA:   state_nxt = FALHA;
        default: state_nxt = OCIOSO;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as estado.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OCIOSO;
      cnt      <= 8'd0;
      bomba    <= 1'b0;
      limpeza  <= 1'b0;
      aspergir <= 1'b0;
      gotejar  <= 1'b0;
      alarme   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bomba    <= (state_nxt == ENCHER);
      limpeza  <= (state_nxt == LIMPAR);
      aspergir <= (state_nxt == ASPERGIR);
      gotejar  <= (state_nxt == GOTEJAR);
      alarme   <= (state_nxt == FALHA);
      if (press || state_nxt != state) begin
        cnt <= 8'd0;
      end else if (tick && cnt != 8'hff &&
                   (state == ENCHER || state == LIMPAR || state == ASPERGIR)) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_irrigacao.sv
// Bench for seq_irrigacao: directed scenarios plus a randomized walk checked
// against a per-tick rule model of the irrigation sequence.
module tb_seq_irrigacao;

  localparam int T_LIMPA      = 5;
  localparam int T_ESP        = 15;
  localparam int T_ENCHER_MAX = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       botao = 1'b0;
  logic       us = 1'b1;
  logic       ua = 1'b0;
  logic       t = 1'b0;
  logic       nivel_baixo = 1'b0;
  logic       nivel_alto = 1'b0;
  logic       bomba, limpeza, aspergir, gotejar, alarme;
  logic [2:0] estado;
  logic [7:0] obs;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int m_st = 0;
  int m_n  = 0;

  seq_irrigacao #(
    .T_LIMPA(T_LIMPA), .T_ESP(T_ESP), .T_ENCHER_MAX(T_ENCHER_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .botao(botao), .us(us), .ua(ua),
    .t(t), .nivel_baixo(nivel_baixo), .nivel_alto(nivel_alto), .bomba(bomba),
    .limpeza(limpeza), .aspergir(aspergir), .gotejar(gotejar), .alarme(alarme),
    .estado(estado)
  );

  always #5 clk = ~clk;

  assign obs = {estado, bomba, limpeza, aspergir, gotejar, alarme};

  // Expected {estado, bomba, limpeza, aspergir, gotejar, alarme} for a state code.
  function automatic logic [7:0] expv(input int st);
    return {3'(st), st == 1, st == 2, st == 3, st == 4, st == 5};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic set_sensors(input logic s_us, s_ua, s_t, s_nb, s_na);
    us = s_us; ua = s_ua; t = s_t; nivel_baixo = s_nb; nivel_alto = s_na;
    settle(3);
  endtask

  task automatic press_button();
    botao = 1'b1;
    settle(4);
    botao = 1'b0;
    settle(3);
  endtask

  // One tick of the irrigation rules; m_n counts ticks already spent in the phase.
  task automatic model_tick();
    int nx;
    nx = m_st;
    if (m_st == 5) nx = 5;
    else if ((m_st == 0 || m_st == 1) && nivel_baixo && nivel_alto) nx = 5;
    else if (m_st != 1 && nivel_baixo) nx = 1;
    else begin
      case (m_st)
        0: if (!us && ua && t) nx = 4; else if (!us) nx = 3;
        1: if (nivel_alto) nx = 2; else if (m_n + 1 == T_ENCHER_MAX) nx = 5;
        2: if (m_n + 1 == T_LIMPA) nx = 0;
        3: if (us) nx = 0; else if (ua && !t && m_n + 1 == T_ESP) nx = 4;
        4: if (us) nx = 0;
        default: nx = 0;
      endcase
    end
    if (nx != m_st) m_n = 0;
    else if (m_st >= 1 && m_st <= 3 && m_n < 255) m_n++;
    m_st = nx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    us = 1'b0; ua = 1'b0; t = 1'b0; nivel_baixo = 1'b0; nivel_alto = 1'b0;
    settle(2);
    vec_cnt++;
    if (obs !== 8'h00) begin
      miss_cnt++; $display("FAIL reset_state: got %h expected %h", obs, 8'h00);
    end
    rst_n = 1'b1;
    settle(6);
    vec_cnt++;
    if (obs !== 8'h00) begin
      miss_cnt++; $display("FAIL no_tick_hold: got %h expected %h", obs, 8'h00);
    end
    do_tick();
    vec_cnt++;
    if (obs !== expv(3)) begin
      miss_cnt++; $display("FAIL first_tick: got %h expected %h", obs, expv(3));
    end
    set_sensors(1, 0, 0, 0, 0);
    do_tick();
    vec_cnt++;
    if (obs !== expv(0)) begin
      miss_cnt++; $display("FAIL wet_to_idle: got %h expected %h", obs, expv(0));
    end
  endtask

  task automatic test_held_button_reset();
    rst_n = 1'b0;
    botao = 1'b1;
    us = 1'b0; ua = 1'b0; t = 1'b0; nivel_baixo = 1'b0; nivel_alto = 1'b0;
    settle(2);
    rst_n = 1'b1;
    do_tick();
    settle(6);
    vec_cnt++;
    if (obs !== expv(3)) begin
      miss_cnt++; $display("FAIL held_button: got %h expected %h", obs, expv(3));
    end
    botao = 1'b0;
    us = 1'b1;
    settle(3);
    press_button();
    vec_cnt++;
    if (obs !== expv(0)) begin
      miss_cnt++; $display("FAIL held_button_exit: got %h expected %h", obs, expv(0));
    end
  endtask

  task automatic test_tank_low();
    set_sensors(1, 0, 0, 1, 0);
    do_tick();
    vec_cnt++;
    if (obs !== expv(1)) begin
      miss_cnt++; $display("FAIL fill_start: got %h expected %h", obs, expv(1));
    end
    set_sensors(1, 0, 0, 0, 1);
    do_tick();
    vec_cnt++;
    if (obs !== expv(2)) begin
      miss_cnt++; $display("FAIL fill_done: got %h expected %h", obs, expv(2));
    end
    set_sensors(1, 0, 0, 0, 0);
    for (int i = 1; i <= T_LIMPA; i++) begin
      do_tick();
      vec_cnt++;
      if (obs !== expv(i == T_LIMPA ? 0 : 2)) begin
        miss_cnt++;
        $display("FAIL clean_tick%0d: got %h expected %h", i, obs, expv(i == T_LIMPA ? 0 : 2));
      end
    end
  endtask

  task automatic test_fill_timeout();
    set_sensors(1, 0, 0, 1, 0);
    do_tick();
    for (int i = 1; i <= T_ENCHER_MAX; i++) begin
      do_tick();
      vec_cnt++;
      if (obs !== expv(i == T_ENCHER_MAX ? 5 : 1)) begin
        miss_cnt++;
        $display("FAIL fill_tick%0d: got %h expected %h", i, obs, expv(i == T_ENCHER_MAX ? 5 : 1));
      end
    end
    set_sensors(0, 1, 1, 0, 1);
    repeat (3) do_tick();
    set_sensors(1, 0, 0, 1, 1);
    repeat (3) do_tick();
    vec_cnt++;
    if (obs !== expv(5)) begin
      miss_cnt++; $display("FAIL fault_sticky: got %h expected %h", obs, expv(5));
    end
    set_sensors(1, 0, 0, 0, 0);
    press_button();
    vec_cnt++;
    if (obs !== expv(0)) begin
      miss_cnt++; $display("FAIL fault_clear: got %h expected %h", obs, expv(0));
    end
  endtask

  task automatic test_special_case();
    set_sensors(0, 1, 0, 0, 0);
    do_tick();
    for (int i = 1; i <= T_ESP; i++) begin
      vec_cnt++;
      if (obs !== expv(3)) begin
        miss_cnt++; $display("FAIL sprinkle_tick%0d: got %h expected %h", i, obs, expv(3));
      end
      do_tick();
    end
    vec_cnt++;
    if (obs !== expv(4)) begin
      miss_cnt++; $display("FAIL special_to_drip: got %h expected %h", obs, expv(4));
    end
    set_sensors(1, 1, 0, 0, 0);
    do_tick();
    vec_cnt++;
    if (obs !== expv(0)) begin
      miss_cnt++; $display("FAIL drip_wet: got %h expected %h", obs, expv(0));
    end
  endtask

  task automatic test_normal_drip();
    set_sensors(0, 1, 1, 0, 0);
    do_tick();
    vec_cnt++;
    if (obs !== expv(4)) begin
      miss_cnt++; $display("FAIL normal_drip: got %h expected %h", obs, expv(4));
    end
    set_sensors(0, 1, 1, 1, 0);
    do_tick();
    vec_cnt++;
    if (obs !== expv(1)) begin
      miss_cnt++; $display("FAIL drip_to_fill: got %h expected %h", obs, expv(1));
    end
    set_sensors(1, 0, 0, 0, 0);
    press_button();
  endtask

  task automatic test_abort();
    set_sensors(0, 0, 0, 0, 0);
    do_tick();
    botao = 1'b1;
    settle(4);
    vec_cnt++;
    if (obs !== expv(0)) begin
      miss_cnt++; $display("FAIL abort_press: got %h expected %h", obs, expv(0));
    end
    botao = 1'b0;
    set_sensors(1, 0, 0, 1, 0);
    do_tick();
    set_sensors(1, 0, 0, 0, 1);
    do_tick();
    do_tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (obs !== 8'h00) begin
      miss_cnt++; $display("FAIL async_reset: got %h expected %h", obs, 8'h00);
    end
    nivel_alto = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle(4);
  endtask

  task automatic test_random();
    m_st = 0;
    m_n  = 0;
    set_sensors(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        set_sensors($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 11) == 0) begin
        press_button();
        m_st = 0;
        m_n  = 0;
      end else begin
        do_tick();
        model_tick();
      end
      vec_cnt++;
      if (obs !== expv(m_st)) begin
        miss_cnt++; $display("FAIL random_step%0d: got %h expected %h", i, obs, expv(m_st));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_held_button_reset();
    test_tank_low();
    test_fill_timeout();
    test_special_case();
    test_normal_drip();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/seq_irrigacao.md
SEQ_IRRIGACAO -- requirements
Module: seq_irrigacao

Interface
REQ-001 Parameter T_LIMPA, default 5, length of the cleaning phase in ticks.
REQ-002 Parameter T_ESP, default 15, length of the special-case sprinkle phase in ticks before switching to drip.
REQ-003 Parameter T_ENCHER_MAX, default 60, fill timeout in ticks; range 1..255.
REQ-004 clk  in  1  single system clock, all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 tick  in  1  synchronous one-cycle enable pulse (time base); all timing and transitions advance only on tick=1, except botao handling.
REQ-007 botao  in  1  manual abort/acknowledge push-button, asynchronous level.
REQ-008 us  in  1  soil moisture sensor, 1 = soil wet, asynchronous.
REQ-009 ua  in  1  air humidity sensor, 1 = air humid, asynchronous.
REQ-010 t  in  1  temperature sensor, 1 = temperature high, asynchronous.
REQ-011 nivel_baixo  in  1  tank low-level sensor, asynchronous.
REQ-012 nivel_alto  in  1  tank high-level sensor, asynchronous.
REQ-013 bomba  out  1  fill pump/valve on.
REQ-014 limpeza  out  1  cleaning flush on.
REQ-015 aspergir  out  1  sprinkler on.
REQ-016 gotejar  out  1  drip line on.
REQ-017 alarme  out  1  fill fault indicator.
REQ-018 estado  out  3  current state code.

Function
REQ-019 All asynchronous inputs pass through 2-flop synchronizers; botao additionally rising-edge detected into a one-cycle press pulse.
REQ-020 States and estado codes: OCIOSO=0, ENCHER=1, LIMPAR=2, ASPERGIR=3, GOTEJAR=4, FALHA=5; codes 6-7 unreachable and return to OCIOSO on the next clock.
REQ-021 Outputs registered and decoded from state: ENCHER->bomba, LIMPAR->limpeza, ASPERGIR->aspergir, GOTEJAR->gotejar, FALHA->alarme; at most one output high at any time.
REQ-022 casoEsp = ua AND NOT t (synchronized values).
REQ-023 Phase counter 8 bits, cleared on every state entry, incremented on tick while in ENCHER, LIMPAR or ASPERGIR; saturates at 255.
REQ-024 Priority each cycle: press pulse > nivel_baixo > state-specific rule.
REQ-025 Press pulse in any state -> OCIOSO on next clock, independent of tick.
REQ-026 OCIOSO, on tick: nivel_baixo -> ENCHER; else NOT us and ua and t -> GOTEJAR; else NOT us -> ASPERGIR; else stay.
REQ-027 ENCHER, on tick: nivel_alto -> LIMPAR; else counter reaching T_ENCHER_MAX-1 on this tick -> FALHA; nivel_baixo does not restart ENCHER.
REQ-028 LIMPAR: exactly T_LIMPA ticks, then OCIOSO.
REQ-029 ASPERGIR, on tick: nivel_baixo -> ENCHER; us -> OCIOSO; casoEsp and counter reaching T_ESP-1 -> GOTEJAR; else stay.
REQ-030 GOTEJAR, on tick: nivel_baixo -> ENCHER; us -> OCIOSO; else stay.
REQ-031 FALHA ignores tick and all sensors; exits only on press pulse.
REQ-032 Latency: sensor edge to state change = 2 clocks sync + first following tick + 1 clock; state to output 0 extra clocks beyond register.
REQ-033 nivel_alto and nivel_baixo both high (sensor conflict) in OCIOSO/ENCHER -> FALHA on tick.

Reset
REQ-034 rst_n=0 asynchronously forces OCIOSO, counter 0, synchronizers and edge detector 0, all outputs 0, estado=0; mid-phase reset discards the phase.
REQ-035 After rst_n release, no transition before the first tick, and no press pulse generated if botao is held high through reset release.

Verification
REQ-036 Tank low: nivel_baixo=1, ticks -> bomba=1, estado=1; set nivel_alto=1 -> next tick estado=2, limpeza=1 for 5 ticks, then estado=0.
REQ-037 Fill timeout: nivel_baixo=1, nivel_alto held 0 -> alarme=1, estado=5 after tick 60; extra ticks/sensors no effect; botao press -> estado=0.
REQ-038 Special case: us=0, ua=1, t=0 -> estado=3 for 15 ticks, then estado=4; set us=1 -> next tick estado=0.
REQ-039 Normal drip: us=0, ua=1, t=1 -> estado=4, gotejar=1; nivel_baixo=1 mid-drip -> next tick estado=1.
REQ-040 Abort: during ASPERGIR, botao pulse with tick=0 -> estado=0 within 4 clocks; assert rst_n=0 mid-LIMPAR -> all outputs 0 immediately.
